// File: rtl/hub75_slice_scheduler_if.sv
// Handshake/bus bundle between the slice scheduler, angle tracker, frame manager and HUB75 shifter.
// Latency: none (wires only).
// Backpressure: the shifter stalls the scheduler by withholding shift_done_in.
interface hub75_slice_scheduler_if #(
    parameter int THETA_W = 10,
    parameter int ROW_W   = 5,
    parameter int PLANE_W = 2
);
    logic               enable_in;
    logic [THETA_W-1:0] dtheta_in;
    logic [THETA_W-1:0] slice_theta_out;
    logic               shift_req_out;
    logic [ROW_W-1:0]   shift_row_out;
    logic [PLANE_W-1:0] shift_plane_out;
    logic               shift_done_in;
    logic [ROW_W-1:0]   hub75_addr_out;
    logic               hub75_latch_out;
    logic               hub75_oe_n_out;
    logic               busy_out;
    logic [7:0]         overrun_count_out;

    modport master (
        input  enable_in, dtheta_in, shift_done_in,
        output slice_theta_out, shift_req_out, shift_row_out, shift_plane_out,
               hub75_addr_out, hub75_latch_out, hub75_oe_n_out, busy_out, overrun_count_out
    );

    modport slave (
        output enable_in, dtheta_in, shift_done_in,
        input  slice_theta_out, shift_req_out, shift_row_out, shift_plane_out,
               hub75_addr_out, hub75_latch_out, hub75_oe_n_out, busy_out, overrun_count_out
    );
endinterface

// File: rtl/hub75_slice_scheduler.sv
// Walks every row/bit plane of one angular slice: shift request, latch, binary-weighted OE window.
// Latency: slice starts one edge after an angle change; per plane S + 1 + (BASE_OE << p) cycles.
// Backpressure: SHIFT holds until shift_done_in; angle changes seen while busy are counted as overruns.
module hub75_slice_scheduler #(
    parameter int SCAN_RATE  = 32,
    parameter int BIT_PLANES = 3,
    parameter int BASE_OE    = 8,
    parameter int THETA_W    = 10
) (
    input  logic                    clk_in,
    input  logic                    rst_n_in,
    hub75_slice_scheduler_if.master bus
);
    localparam int ROW_W   = $clog2(SCAN_RATE);
    localparam int PLANE_W = ($clog2(BIT_PLANES) > 1) ? $clog2(BIT_PLANES) : 1;
    localparam int CNT_W   = $clog2(BASE_OE << (BIT_PLANES - 1)) + 1;

    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(SCAN_RATE - 1);
    localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(BIT_PLANES - 1);
    localparam logic [CNT_W-1:0]   OE_BASE    = CNT_W'(BASE_OE);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

    state_t             state_q, state_nxt;
    logic [ROW_W-1:0]   row_q, row_nxt;
    logic [PLANE_W-1:0] plane_q, plane_nxt;
    logic [CNT_W-1:0]   cnt_q, cnt_nxt;
    logic [CNT_W-1:0]   oe_load;
    logic [THETA_W-1:0] theta_nxt;
    logic [THETA_W-1:0] dtheta_prev_q;
    logic               start;
    logic               overrun_hit;

    assign start       = bus.enable_in && (bus.dtheta_in != bus.slice_theta_out);
    assign overrun_hit = bus.busy_out && (bus.dtheta_in != dtheta_prev_q) &&
                         (bus.overrun_count_out != 8'hFF);
    // Counter runs W-1 .. 0 so the OE window is exactly W cycles long.
    assign oe_load     = (OE_BASE << plane_q) - CNT_W'(1);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            row_q   <= '0;
            plane_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_nxt;
            row_q   <= row_nxt;
            plane_q <= plane_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        row_nxt   = row_q;
        plane_nxt = plane_q;
        cnt_nxt   = cnt_q;
        theta_nxt = bus.slice_theta_out;
        case (state_q)
            IDLE: begin
                if (start) begin
                    theta_nxt = bus.dtheta_in;
                    row_nxt   = '0;
                    plane_nxt = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (bus.shift_done_in) state_nxt = LATCH;
            end
            LATCH: begin
                cnt_nxt   = oe_load;
                state_nxt = DISPLAY;
            end
            DISPLAY: begin
                if (cnt_q != '0) begin
                    cnt_nxt = cnt_q - CNT_W'(1);
                end else if (plane_q != LAST_PLANE) begin
                    plane_nxt = plane_q + PLANE_W'(1);
                    state_nxt = SHIFT;
                end else if (row_q != LAST_ROW) begin
                    row_nxt   = row_q + ROW_W'(1);
                    plane_nxt = '0;
                    state_nxt = SHIFT;
                end else begin
                    row_nxt   = '0;
                    plane_nxt = '0;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Outputs are registered from the next-state view so they line up with state_q.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            bus.slice_theta_out   <= '0;
            bus.shift_req_out     <= 1'b0;
            bus.shift_row_out     <= '0;
            bus.shift_plane_out   <= '0;
            bus.hub75_addr_out    <= '0;
            bus.hub75_latch_out   <= 1'b0;
            bus.hub75_oe_n_out    <= 1'b1;
            bus.busy_out          <= 1'b0;
            bus.overrun_count_out <= '0;
            dtheta_prev_q         <= '0;
        end else begin
            bus.slice_theta_out <= theta_nxt;
            bus.shift_req_out   <= (state_nxt == SHIFT);
            bus.shift_row_out   <= row_nxt;
            bus.shift_plane_out <= plane_nxt;
            bus.hub75_latch_out <= (state_nxt == LATCH);
            bus.hub75_oe_n_out  <= (state_nxt != DISPLAY);
            bus.busy_out        <= (state_nxt != IDLE);
            if (state_nxt == LATCH) bus.hub75_addr_out <= row_nxt;
            dtheta_prev_q <= bus.dtheta_in;
            if (overrun_hit) bus.overrun_count_out <= bus.overrun_count_out + 8'd1;
        end
    end
endmodule

// File: tb/tb_hub75_slice_scheduler.sv
// Bench for hub75_slice_scheduler: start/reset vector table, full slices against an ideal schedule,
// shifter stall, enable drop, randomized shifter delays and angle churn, mid-slice async reset.
module tb_hub75_slice_scheduler;
    localparam int SCAN_RATE  = 32;
    localparam int BIT_PLANES = 3;
    localparam int BASE_OE    = 8;
    localparam int THETA_W    = 10;
    localparam int ROW_W      = 5;
    localparam int PLANE_W    = 2;
    localparam int NREQ       = SCAN_RATE * BIT_PLANES;

    typedef struct {
        logic               en;
        logic [THETA_W-1:0] th;
        logic               exp_busy;
        logic [THETA_W-1:0] exp_theta;
    } vec_t;

    logic clk_in = 1'b0;
    logic rst_n_in;

    hub75_slice_scheduler_if #(.THETA_W(THETA_W), .ROW_W(ROW_W), .PLANE_W(PLANE_W)) bus ();

    hub75_slice_scheduler #(
        .SCAN_RATE(SCAN_RATE), .BIT_PLANES(BIT_PLANES), .BASE_OE(BASE_OE), .THETA_W(THETA_W)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .bus(bus)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    // Ideal busy time of a slice given the summed SHIFT dwell of all its planes.
    function automatic int model_busy(input int sum_s);
        return sum_s + NREQ + SCAN_RATE * BASE_OE * ((1 << BIT_PLANES) - 1);
    endfunction

    // ---------------- shifter model ----------------
    logic rand_delay = 1'b0;
    logic spur_en    = 1'b0;
    logic stall_on   = 1'b0;
    int   wait_left  = -1;
    int   s_sum      = 0;

    always @(negedge clk_in) begin
        if (bus.shift_req_out) begin
            if (wait_left < 0) begin
                wait_left = rand_delay ? int'($urandom_range(0, 3)) : 0;
                if (stall_on && bus.shift_row_out == 5'd3 && bus.shift_plane_out == 2'd1)
                    wait_left += 50;
                s_sum += wait_left + 1;
            end
            if (wait_left == 0) begin
                bus.shift_done_in = 1'b1;
                wait_left = -1;
            end else begin
                bus.shift_done_in = 1'b0;
                wait_left--;
            end
        end else begin
            bus.shift_done_in = spur_en ? 1'($urandom_range(0, 1)) : 1'b0;
        end
    end

    // ---------------- observation ----------------
    int   busy_cycles  = 0;
    int   proto_err    = 0;
    int   oe_run       = 0;
    int   req_log[$];
    int   oe_log[$];
    logic prev_req     = 1'b0;
    logic prev_latch   = 1'b0;
    logic prev_oe_n    = 1'b1;
    logic [ROW_W-1:0] last_req_row = '0;

    always @(negedge clk_in) begin
        if (bus.busy_out) busy_cycles++;
        if (bus.shift_req_out && !prev_req) begin
            req_log.push_back(int'(bus.shift_row_out) * 4 + int'(bus.shift_plane_out));
            last_req_row = bus.shift_row_out;
        end
        if (bus.hub75_latch_out &&
            (!bus.hub75_oe_n_out || prev_latch || bus.hub75_addr_out != last_req_row))
            proto_err++;
        if (prev_latch && bus.hub75_oe_n_out) proto_err++;
        if (!bus.hub75_oe_n_out && prev_oe_n && !prev_latch) proto_err++;
        if (bus.shift_req_out && !bus.hub75_oe_n_out) proto_err++;
        if (!bus.hub75_oe_n_out) oe_run++;
        else if (oe_run != 0) begin
            oe_log.push_back(oe_run);
            oe_run = 0;
        end
        prev_req   = bus.shift_req_out;
        prev_latch = bus.hub75_latch_out;
        prev_oe_n  = bus.hub75_oe_n_out;
    end

    // ---------------- helpers ----------------
    task automatic check_reset_vals(input string tag);
        chk({tag, "_theta"},   int'(bus.slice_theta_out), 0);
        chk({tag, "_req"},     int'(bus.shift_req_out), 0);
        chk({tag, "_row"},     int'(bus.shift_row_out), 0);
        chk({tag, "_plane"},   int'(bus.shift_plane_out), 0);
        chk({tag, "_addr"},    int'(bus.hub75_addr_out), 0);
        chk({tag, "_latch"},   int'(bus.hub75_latch_out), 0);
        chk({tag, "_oe_n"},    int'(bus.hub75_oe_n_out), 1);
        chk({tag, "_busy"},    int'(bus.busy_out), 0);
        chk({tag, "_overrun"}, int'(bus.overrun_count_out), 0);
    endtask

    task automatic wait_busy_low(input string name, input int limit);
        int n = 0;
        do begin
            @(negedge clk_in);
            n++;
        end while (bus.busy_out && n < limit);
        chk({name, "_ends"}, int'(bus.busy_out), 0);
        @(negedge clk_in);
    endtask

    task automatic wait_req(input string name, input int row, input int plane, input int limit);
        int n = 0;
        logic hit;
        do begin
            @(negedge clk_in);
            n++;
            hit = bus.shift_req_out && int'(bus.shift_row_out) == row &&
                  int'(bus.shift_plane_out) == plane;
        end while (!hit && n < limit);
        chk(name, int'(hit), 1);
    endtask

    task automatic idle_check(input string name, input int cycles);
        int ok = 0;
        repeat (cycles) begin
            @(negedge clk_in);
            if (!bus.busy_out && !bus.shift_req_out && bus.hub75_oe_n_out) ok++;
        end
        chk(name, ok, cycles);
    endtask

    task automatic check_slice(input string tag, input int rb, input int ob, input int bb,
                               input int eb, input int exp_busy);
        int req_mis = 0;
        int oe_mis  = 0;
        chk({tag, "_req_count"}, req_log.size() - rb, NREQ);
        chk({tag, "_oe_count"},  oe_log.size() - ob, NREQ);
        for (int i = 0; i < NREQ; i++) begin
            if (rb + i >= req_log.size() ||
                req_log[rb + i] != (i / BIT_PLANES) * 4 + (i % BIT_PLANES)) req_mis++;
            if (ob + i >= oe_log.size() ||
                oe_log[ob + i] != (BASE_OE << (i % BIT_PLANES))) oe_mis++;
        end
        chk({tag, "_req_order"},   req_mis, 0);
        chk({tag, "_oe_widths"},   oe_mis, 0);
        chk({tag, "_busy_cycles"}, busy_cycles - bb, exp_busy);
        chk({tag, "_protocol"},    proto_err - eb, 0);
    endtask

    // ---------------- stimulus ----------------
    vec_t vecs[6];
    int   rb, ob, bb, eb, sb;
    int   ov_model;
    int   nchg;
    int   ok;

    initial begin
        vecs[0] = '{1'b1, 10'd5,    1'b1, 10'd5};
        vecs[1] = '{1'b0, 10'd5,    1'b0, 10'd0};
        vecs[2] = '{1'b1, 10'd0,    1'b0, 10'd0};
        vecs[3] = '{1'b1, 10'd1023, 1'b1, 10'd1023};
        vecs[4] = '{1'b0, 10'd0,    1'b0, 10'd0};
        vecs[5] = '{1'b1, 10'd512,  1'b1, 10'd512};

        rst_n_in      = 1'b0;
        bus.enable_in = 1'b0;
        bus.dtheta_in = '0;
        ov_model      = 0;

        // Start decision straight out of reset.
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            rst_n_in      = 1'b0;
            bus.enable_in = vecs[i].en;
            bus.dtheta_in = vecs[i].th;
            #1;
            if (i == 0) check_reset_vals("reset");
            @(negedge clk_in);
            rst_n_in = 1'b1;
            @(negedge clk_in);
            chk($sformatf("vec%0d_busy", i),  int'(bus.busy_out), int'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_req", i),   int'(bus.shift_req_out), int'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_theta", i), int'(bus.slice_theta_out), int'(vecs[i].exp_theta));
            chk($sformatf("vec%0d_oe_n", i),  int'(bus.hub75_oe_n_out), 1);
            chk($sformatf("vec%0d_latch", i), int'(bus.hub75_latch_out), 0);
        end

        // Full slice, shifter answers one cycle after each request.
        @(negedge clk_in);
        rst_n_in      = 1'b0;
        bus.enable_in = 1'b1;
        bus.dtheta_in = 10'd5;
        repeat (2) @(negedge clk_in);
        rb = req_log.size(); ob = oe_log.size(); bb = busy_cycles; eb = proto_err;
        rst_n_in = 1'b1;
        wait_busy_low("slice_main", 5000);
        chk("main_theta", int'(bus.slice_theta_out), 5);
        chk("main_overrun", int'(bus.overrun_count_out), ov_model);
        check_slice("main", rb, ob, bb, eb, 1984);
        idle_check("main_stays_idle", 5);

        // Shifter stalls 50 cycles on r3p1.
        rb = req_log.size(); ob = oe_log.size(); bb = busy_cycles; eb = proto_err;
        bus.dtheta_in = 10'd7;
        stall_on      = 1'b1;
        wait_req("stall_reach", 3, 1, 3000);
        ok = 0;
        repeat (50) begin
            @(negedge clk_in);
            if (bus.shift_req_out && bus.hub75_oe_n_out && !bus.hub75_latch_out &&
                bus.shift_row_out == 5'd3 && bus.shift_plane_out == 2'd1) ok++;
        end
        chk("stall_hold", ok, 50);
        @(negedge clk_in);
        chk("stall_latch_after_done", int'(bus.hub75_latch_out), 1);
        stall_on = 1'b0;
        wait_busy_low("slice_stall", 5000);
        chk("stall_theta", int'(bus.slice_theta_out), 7);
        chk("stall_overrun", int'(bus.overrun_count_out), ov_model);
        check_slice("stall", rb, ob, bb, eb, 1984 + 50);

        // Enable dropped at row 5: slice still completes, then holds IDLE.
        rb = req_log.size(); ob = oe_log.size(); bb = busy_cycles; eb = proto_err;
        bus.dtheta_in = 10'd9;
        wait_req("en_drop_reach", 5, 0, 3000);
        bus.enable_in = 1'b0;
        wait_busy_low("slice_en_drop", 5000);
        chk("en_drop_theta", int'(bus.slice_theta_out), 9);
        check_slice("en_drop", rb, ob, bb, eb, 1984);
        bus.dtheta_in = 10'd12;
        idle_check("en_off_idle", 5);

        // Re-enable: random shifter delay, random spurious done, random angle churn.
        rand_delay = 1'b1;
        spur_en    = 1'b1;
        rb = req_log.size(); ob = oe_log.size(); bb = busy_cycles; eb = proto_err; sb = s_sum;
        bus.enable_in = 1'b1;
        @(negedge clk_in);
        chk("reenable_busy", int'(bus.busy_out), 1);
        chk("reenable_theta", int'(bus.slice_theta_out), 12);
        nchg = 0;
        for (int c = 2; c < 1600; c++) begin
            @(negedge clk_in);
            if (c >= 10 && c <= 1500 && $urandom_range(0, 15) == 0) begin
                bus.dtheta_in = bus.dtheta_in ^ THETA_W'($urandom_range(1, 1023));
                nchg++;
            end
        end
        bus.enable_in = 1'b0;
        ov_model = (ov_model + nchg > 255) ? 255 : ov_model + nchg;
        wait_busy_low("slice_rand", 5000);
        chk("rand_theta", int'(bus.slice_theta_out), 12);
        chk("rand_overrun", int'(bus.overrun_count_out), ov_model);
        check_slice("rand", rb, ob, bb, eb, model_busy(s_sum - sb));

        // 300 angle changes mid-slice saturate the counter; then async reset in r10p2 DISPLAY.
        spur_en       = 1'b0;
        bus.dtheta_in = 10'd300;
        bus.enable_in = 1'b1;
        @(negedge clk_in);
        chk("sat_start_busy", int'(bus.busy_out), 1);
        repeat (4) @(negedge clk_in);
        for (int k = 0; k < 300; k++) begin
            @(negedge clk_in);
            bus.dtheta_in = bus.dtheta_in ^ THETA_W'($urandom_range(1, 1023));
        end
        ov_model = (ov_model + 300 > 255) ? 255 : ov_model + 300;
        wait_req("r10p2_reach", 10, 2, 3000);
        ok = 0;
        do begin
            @(negedge clk_in);
            ok++;
        end while (bus.hub75_oe_n_out && ok < 50);
        chk("r10p2_oe_low", int'(bus.hub75_oe_n_out), 0);
        chk("sat_overrun", int'(bus.overrun_count_out), ov_model);
        repeat (3) @(negedge clk_in);
        #2 rst_n_in = 1'b0;
        #1 check_reset_vals("midreset");
        ov_model = 0;
        @(negedge clk_in);
        bus.dtheta_in = '0;
        @(negedge clk_in);
        rst_n_in = 1'b1;
        idle_check("post_reset_idle", 5);
        chk("post_reset_overrun", int'(bus.overrun_count_out), ov_model);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_chk);
        $fatal(1, "timeout");
    end
endmodule
